idft_point_4_seq: RTL



---
 rtl/idft4_pkg.sv | 29 ++
 rtl/idft_point_4_seq_cbfly2_signed.sv | 23 ++
 rtl/idft_point_4_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/idft4_pkg.sv
// Shared definitions for the sequential 4-point inverse DFT.
// State encoding, default data width, stage-width helpers and scaling constants.
// Optional build macro used by the consumer: IDFT4_ROUND_EN (round-half-up scaling).
package idft4_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_ST1  = 2'd1,
        S_ST2  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam int IDFT_DW   = 8;   // Q4.4 sample width
    localparam int IDFT_FRAC = 4;   // fractional bits, informational only

    // 1/4 output scaling and the half-LSB offset used when rounding
    localparam int SCALE_SH = 2;
    localparam int RND_OFS  = 2;

    // Stage widths: each butterfly stage adds one bit of growth
    function automatic int stage1_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int stage2_w(input int dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/idft_point_4_seq_cbfly2_signed.sv
// Complex signed radix-2 butterfly: sum = a + b, dif = a - b, one bit of growth.
// Ports: a_re/a_im, b_re/b_im (W bits, signed) in; sum_re/sum_im, dif_re/dif_im (W+1 bits) out.
// Purely combinational, no latency, no flow control.
module cbfly2_signed #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_re,
    input  logic [W-1:0] a_im,
    input  logic [W-1:0] b_re,
    input  logic [W-1:0] b_im,
    output logic [W:0]   sum_re,
    output logic [W:0]   sum_im,
    output logic [W:0]   dif_re,
    output logic [W:0]   dif_im
);

    // Sign-extend both operands by one bit so the result never wraps
    assign sum_re = {a_re[W-1], a_re} + {b_re[W-1], b_re};
    assign sum_im = {a_im[W-1], a_im} + {b_im[W-1], b_im};
    assign dif_re = {a_re[W-1], a_re} - {b_re[W-1], b_re};
    assign dif_im = {a_im[W-1], a_im} - {b_im[W-1], b_im};

endmodule

// File: rtl/idft_point_4_seq.sv
// Sequential 4-point inverse DFT: 4 bins in (valid/ready), 4 time samples out in natural order.
// Latency: 4th bin accepted at edge N -> out_valid after edge N+2; no input/output overlap.
// Backpressure: in_ready only in S_LOAD; output sample held stable while out_ready is low.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_re/in_im bin stream;
//        out_valid/out_ready/out_re/out_im/out_last sample stream; busy = not loading.
// Build macro: IDFT4_ROUND_EN selects round-half-up 1/4 scaling instead of truncation.
module idft_point_4_seq
    import idft4_pkg::*;
#(
    parameter int DW   = IDFT_DW,
    parameter int FRAC = IDFT_FRAC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_last,
    output logic          busy
);

    localparam int W1 = stage1_w(DW);
    localparam int W2 = stage2_w(DW);

`ifdef IDFT4_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    if (FRAC < 0 || FRAC >= DW) begin : g_frac_range_bad
        $error("FRAC must lie in [0, DW-1]");
    end

    state_t state_q, state_d;

    logic [1:0]    in_cnt_q;
    logic [1:0]    out_cnt_q;
    logic [DW-1:0] x_re_q [4];
    logic [DW-1:0] x_im_q [4];
    logic [W1-1:0] a_re_q [4];
    logic [W1-1:0] a_im_q [4];
    logic [DW-1:0] y_re_q [4];
    logic [DW-1:0] y_im_q [4];

    logic [W1-1:0] s1_re [4];
    logic [W1-1:0] s1_im [4];
    logic [W2-1:0] s2_re [4];
    logic [W2-1:0] s2_im [4];
    logic [DW-1:0] ys_re [4];
    logic [DW-1:0] ys_im [4];
    logic [W1-1:0] rot_re, rot_im;

    logic in_fire, out_fire;

    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q != S_LOAD);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = (state_q == S_OUT) && out_ready;

    // Stage 1: a0 = X0+X2, a1 = X0-X2, a2 = X1+X3, a3 = X1-X3
    cbfly2_signed #(.W(DW)) u_s1_even (
        .a_re(x_re_q[0]), .a_im(x_im_q[0]), .b_re(x_re_q[2]), .b_im(x_im_q[2]),
        .sum_re(s1_re[0]), .sum_im(s1_im[0]), .dif_re(s1_re[1]), .dif_im(s1_im[1])
    );
    cbfly2_signed #(.W(DW)) u_s1_odd (
        .a_re(x_re_q[1]), .a_im(x_im_q[1]), .b_re(x_re_q[3]), .b_im(x_im_q[3]),
        .sum_re(s1_re[2]), .sum_im(s1_im[2]), .dif_re(s1_re[3]), .dif_im(s1_im[3])
    );

    // Inverse twiddle +j: j*(re + j*im) = -im + j*re. a3.im never reaches the
    // most negative W1 value, so the negation cannot wrap.
    assign rot_re = -a_im_q[3];
    assign rot_im = a_re_q[3];

    // Stage 2: y0 = a0+a2, y2 = a0-a2, y1 = a1+j*a3, y3 = a1-j*a3
    cbfly2_signed #(.W(W1)) u_s2_even (
        .a_re(a_re_q[0]), .a_im(a_im_q[0]), .b_re(a_re_q[2]), .b_im(a_im_q[2]),
        .sum_re(s2_re[0]), .sum_im(s2_im[0]), .dif_re(s2_re[2]), .dif_im(s2_im[2])
    );
    cbfly2_signed #(.W(W1)) u_s2_odd (
        .a_re(a_re_q[1]), .a_im(a_im_q[1]), .b_re(rot_re), .b_im(rot_im),
        .sum_re(s2_re[1]), .sum_im(s2_im[1]), .dif_re(s2_re[3]), .dif_im(s2_im[3])
    );

    // Divide by 4 with an arithmetic shift; the optional half-LSB offset turns
    // floor into round-half-up.
    function automatic logic [DW-1:0] scale(input logic [W2-1:0] y);
        logic signed [W2-1:0] t;
        t = ROUND_EN ? $signed(y) + W2'(RND_OFS) : $signed(y);
        return DW'(t >>> SCALE_SH);
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ys_re[i] = scale(s2_re[i]);
            ys_im[i] = scale(s2_im[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_LOAD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (in_fire && in_cnt_q == 2'd3) state_d = S_ST1;
            S_ST1:   state_d = S_ST2;
            S_ST2:   state_d = S_OUT;
            S_OUT:   if (out_fire && out_cnt_q == 2'd3) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            for (int i = 0; i < 4; i++) begin
                x_re_q[i] <= '0;
                x_im_q[i] <= '0;
                a_re_q[i] <= '0;
                a_im_q[i] <= '0;
                y_re_q[i] <= '0;
                y_im_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_fire) begin
                        x_re_q[in_cnt_q] <= in_re;
                        x_im_q[in_cnt_q] <= in_im;
                        in_cnt_q         <= in_cnt_q + 2'd1;  // wraps 3 -> 0
                    end
                end
                S_ST1: begin
                    for (int i = 0; i < 4; i++) begin
                        a_re_q[i] <= s1_re[i];
                        a_im_q[i] <= s1_im[i];
                    end
                end
                S_ST2: begin
                    for (int i = 0; i < 4; i++) begin
                        y_re_q[i] <= ys_re[i];
                        y_im_q[i] <= ys_im[i];
                    end
                    // x0 goes straight to the output register so it is valid next cycle
                    out_re    <= ys_re[0];
                    out_im    <= ys_im[0];
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                end
                S_OUT: begin
                    if (out_fire) begin
                        if (out_cnt_q == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_cnt_q <= '0;
                        end else begin
                            out_re    <= y_re_q[out_cnt_q + 2'd1];
                            out_im    <= y_im_q[out_cnt_q + 2'd1];
                            out_last  <= (out_cnt_q == 2'd2);
                            out_cnt_q <= out_cnt_q + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
